// File: rtl/arbiter_nx1_pkg.sv
// ============================================================================
//  arbiter_nx1_pkg
//  Common types and helpers for the N-to-1 bus arbiter.
//  Rev 1.0 - initial release
// ============================================================================
`include "defines.vh"
`default_nettype none

package arbiter_nx1_pkg;

    localparam int         XLEN      = `XLEN;
    localparam logic [4:0] FUNCT5_LR = `FUNCT5_LR;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Load-reserved: atomic access whose funct5 field selects LR.
    function automatic logic is_lr(input logic atomic, input logic [6:0] operation);
        return atomic && (operation[6:2] == FUNCT5_LR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/defines.vh
// ============================================================================
//  defines.vh
//  Shared bus-width and RISC-V AMO encoding macros.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef ARB_DEFINES_VH
`define ARB_DEFINES_VH
`default_nettype none

`define XLEN      32
`define FUNCT5_LR 5'b00010

`default_nettype wire
`endif

// File: rtl/rr_picker.sv
// ============================================================================
//  rr_picker
//  Combinational round-robin search: first set request at or after i_start.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_start,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, i_start} + (ID_W + 1)'(off);
            if (w_sum >= (ID_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(N_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbiter_nx1.sv
// ============================================================================
//  arbiter_nx1
//  Round-robin N-to-1 bus arbiter with LR/SC reservation lock and timeout.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_nx1
    import arbiter_nx1_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int LOCK_TIMEOUT = 64,
    localparam int ID_W        = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_PORTS-1:0]      i_bus_en,
    input  logic [N_PORTS-1:0]      i_wr_en,
    input  logic [N_PORTS*XLEN-1:0] i_wr_data,
    input  logic [N_PORTS*XLEN-1:0] i_addr,
    input  logic [N_PORTS*4-1:0]    i_byte_en,
    input  logic [N_PORTS-1:0]      i_atomic,
    input  logic [N_PORTS*7-1:0]    i_operation,
    output logic [N_PORTS-1:0]      o_ack,
    output logic [N_PORTS*XLEN-1:0] o_rd_data,
    input  logic                    i_ack,
    input  logic [XLEN-1:0]         i_rd_data,
    output logic [ID_W-1:0]         o_id,
    output logic                    o_bus_en,
    output logic                    o_wr_en,
    output logic                    o_atomic,
    output logic [XLEN-1:0]         o_wr_data,
    output logic [XLEN-1:0]         o_addr,
    output logic [3:0]              o_byte_en,
    output logic [6:0]              o_operation
);

    localparam int              CNT_W       = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  c_last_port = ID_W'(N_PORTS - 1);

    arb_state_t       r_state, w_state_n;
    logic [ID_W-1:0]  r_grant, w_grant_n;
    logic [ID_W-1:0]  r_last_grant, w_last_n;
    logic [ID_W-1:0]  r_owner, w_owner_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;

    logic [XLEN-1:0]  w_wr_data   [N_PORTS];
    logic [XLEN-1:0]  w_addr      [N_PORTS];
    logic [3:0]       w_byte_en   [N_PORTS];
    logic [6:0]       w_operation [N_PORTS];

    logic             w_active;
    logic             w_ack_fire;
    logic             w_grant_lr;
    logic             w_pick_valid;
    logic [ID_W-1:0]  w_pick_idx;
    logic [ID_W-1:0]  w_start;

    for (genvar k = 0; k < N_PORTS; k++) begin : g_port
        assign w_wr_data[k]   = i_wr_data[k*XLEN +: XLEN];
        assign w_addr[k]      = i_addr[k*XLEN +: XLEN];
        assign w_byte_en[k]   = i_byte_en[k*4 +: 4];
        assign w_operation[k] = i_operation[k*7 +: 7];
        assign o_ack[k]                  = w_ack_fire && (r_grant == ID_W'(k));
        assign o_rd_data[k*XLEN +: XLEN] = o_ack[k] ? i_rd_data : '0;
    end

    assign w_start = (r_last_grant == c_last_port) ? '0 : r_last_grant + ID_W'(1);

    rr_picker #(
        .N_REQ (N_PORTS),
        .ID_W  (ID_W)
    ) u_rr_picker (
        .i_req   (i_bus_en),
        .i_start (w_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Reset gates the outputs so nothing leaks during the reset cycle itself.
    assign w_active    = (r_state == ST_BUSY) && !i_rst;
    assign w_ack_fire  = w_active && i_ack;
    assign w_grant_lr  = is_lr(i_atomic[r_grant], w_operation[r_grant]);

    assign o_bus_en    = w_active && i_bus_en[r_grant];
    assign o_wr_en     = w_active && i_wr_en[r_grant];
    assign o_atomic    = w_active && i_atomic[r_grant];
    assign o_id        = w_active ? r_grant : '0;
    assign o_wr_data   = w_active ? w_wr_data[r_grant]   : '0;
    assign o_addr      = w_active ? w_addr[r_grant]      : '0;
    assign o_byte_en   = w_active ? w_byte_en[r_grant]   : '0;
    assign o_operation = w_active ? w_operation[r_grant] : '0;

    always_comb begin
        w_state_n = r_state;
        w_grant_n = r_grant;
        w_last_n  = r_last_grant;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_n = w_pick_idx;
                    w_state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_ack) begin
                    w_last_n = r_grant;
                    if (w_grant_lr) begin
                        w_state_n = ST_LOCKED;
                        w_owner_n = r_grant;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end else if (!i_bus_en[r_grant]) begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (i_bus_en[r_owner]) begin
                    w_grant_n = r_owner;
                    w_state_n = ST_BUSY;
                end else if (r_cnt >= c_cnt_last) begin
                    w_state_n = ST_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_last_port;
            r_owner      <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_n;
            r_grant      <= w_grant_n;
            r_last_grant <= w_last_n;
            r_owner      <= w_owner_n;
            r_cnt        <= w_cnt_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arbiter_nx1.sv
// ============================================================================
//  tb_arbiter_nx1
//  Directed and randomized self-checking bench against a transaction model.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter_nx1;
    import arbiter_nx1_pkg::*;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int IDW = 2;
    localparam int W   = XLEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   bus_en, wr_en, atomic;
    logic [W-1:0]   wr_data_a [N];
    logic [W-1:0]   addr_a    [N];
    logic [3:0]     be_a      [N];
    logic [6:0]     op_a      [N];
    logic [N*W-1:0] wr_data_f, addr_f;
    logic [N*4-1:0] be_f;
    logic [N*7-1:0] op_f;
    logic           ack;
    logic [W-1:0]   rd_data;

    logic [N-1:0]   d_ack;
    logic [N*W-1:0] d_rd;
    logic [IDW-1:0] d_id;
    logic           d_bus_en, d_wr_en, d_atomic;
    logic [W-1:0]   d_wr_data, d_addr;
    logic [3:0]     d_be;
    logic [6:0]     d_op;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign wr_data_f[k*W +: W] = wr_data_a[k];
        assign addr_f[k*W +: W]    = addr_a[k];
        assign be_f[k*4 +: 4]      = be_a[k];
        assign op_f[k*7 +: 7]      = op_a[k];
    end

    arbiter_nx1 #(.N_PORTS(N), .LOCK_TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bus_en    (bus_en),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data_f),
        .i_addr      (addr_f),
        .i_byte_en   (be_f),
        .i_atomic    (atomic),
        .i_operation (op_f),
        .o_ack       (d_ack),
        .o_rd_data   (d_rd),
        .i_ack       (ack),
        .i_rd_data   (rd_data),
        .o_id        (d_id),
        .o_bus_en    (d_bus_en),
        .o_wr_en     (d_wr_en),
        .o_atomic    (d_atomic),
        .o_wr_data   (d_wr_data),
        .o_addr      (d_addr),
        .o_byte_en   (d_be),
        .o_operation (d_op)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: owner = -1 means no reservation held.
    bit m_busy;
    int m_grant, m_last, m_owner, m_cnt;

    logic           obs_bus_en;
    int             obs_id;
    logic [N-1:0]   obs_ack;
    logic [N*W-1:0] obs_rd;
    logic [W-1:0]   obs_addr;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit             act;
        logic [N-1:0]   eack;
        logic [N*W-1:0] erd;
        act  = m_busy && !rst;
        eack = '0;
        erd  = '0;
        if (act && ack) begin
            eack[m_grant]         = 1'b1;
            erd[m_grant*W +: W]   = rd_data;
        end
        check_eq("bus_en",    d_bus_en,  act && bus_en[m_grant]);
        check_eq("id",        d_id,      act ? m_grant : 0);
        check_eq("wr_en",     d_wr_en,   act && wr_en[m_grant]);
        check_eq("atomic",    d_atomic,  act && atomic[m_grant]);
        check_eq("wr_data",   d_wr_data, act ? wr_data_a[m_grant] : '0);
        check_eq("addr",      d_addr,    act ? addr_a[m_grant] : '0);
        check_eq("byte_en",   d_be,      act ? be_a[m_grant] : '0);
        check_eq("operation", d_op,      act ? op_a[m_grant] : '0);
        check_eq("ack_vec",   d_ack,     eack);
        check_eq("rd_vec",    d_rd,      erd);
        obs_bus_en = d_bus_en;
        obs_id     = int'(d_id);
        obs_ack    = d_ack;
        obs_rd     = d_rd;
        obs_addr   = d_addr;
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = 0; m_grant = 0; m_last = N - 1; m_owner = -1; m_cnt = 0;
        end else if (m_busy) begin
            if (ack) begin
                m_last = m_grant;
                m_busy = 0;
                if (atomic[m_grant] && op_a[m_grant][6:2] == 5'b00010) begin
                    m_owner = m_grant;
                    m_cnt   = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (!bus_en[m_grant]) begin
                m_busy  = 0;
                m_owner = -1;
            end
        end else if (m_owner >= 0) begin
            if (bus_en[m_owner]) begin
                m_busy  = 1;
                m_grant = m_owner;
            end else if (m_cnt == TO - 1) begin
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (bus_en[p]) begin
                    m_busy  = 1;
                    m_grant = p;
                    break;
                end
            end
        end
    endtask

    // Entered and left 1ns after a rising edge; outputs sampled at the falling edge.
    task automatic cycle();
        #4;
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus_en = '0; wr_en = '0; atomic = '0; ack = 1'b0; rd_data = '0; rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            wr_data_a[k] = '0; addr_a[k] = '0; be_a[k] = '0; op_a[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic await_grant(output int id);
        id = -1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (obs_bus_en) begin
                id = obs_id;
                break;
            end
        end
        if (id < 0) check_eq("grant_wait", obs_bus_en, 1'b1);
    endtask

    task automatic ack_cycle(input logic [W-1:0] d);
        ack = 1'b1;
        rd_data = d;
        cycle();
        ack = 1'b0;
        rd_data = '0;
    endtask

    task automatic new_txn(input int p);
        bus_en[p]    = 1'b1;
        wr_en[p]     = 1'($urandom_range(1));
        wr_data_a[p] = $urandom;
        addr_a[p]    = $urandom;
        be_a[p]      = 4'($urandom);
        atomic[p]    = 1'($urandom_range(1));
        case ($urandom_range(3))
            0: op_a[p] = {5'b00010, 2'($urandom)};
            1: op_a[p] = 7'b0001100;
            2: op_a[p] = 7'($urandom);
            default: op_a[p] = 7'b0000000;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int first;
        int blocked;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        idle_inputs();
        rst = 1'b1;
        m_busy = 0; m_grant = 0; m_last = N - 1; m_owner = -1; m_cnt = 0;
        @(posedge clk);
        model_update();
        #1;

        // Reset state and round-robin rotation with all ports requesting
        do_reset();
        check_eq("reset_bus_en", obs_bus_en, 1'b0);
        check_eq("reset_ack", obs_ack, '0);
        bus_en = 4'hF;
        for (int g = 0; g < 5; g++) begin
            await_grant(id);
            check_eq($sformatf("rr_order%0d", g), id, exp_order[g]);
            ack_cycle($urandom);
            check_eq($sformatf("rr_ack%0d", g), obs_ack, 4'b0001 << exp_order[g]);
        end

        // Read data routed only to the granted port
        idle_inputs();
        do_reset();
        bus_en = 4'b0100;
        addr_a[2] = 32'h100;
        await_grant(id);
        check_eq("read_grant", id, 2);
        check_eq("read_addr", obs_addr, 32'h100);
        ack_cycle(32'hDEADBEEF);
        check_eq("read_ack", obs_ack, 4'b0100);
        check_eq("read_data", obs_rd, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});

        // LR lock blocks other ports until the owner's SC
        idle_inputs();
        do_reset();
        bus_en = 4'b1010;
        atomic[1] = 1'b1;
        op_a[1] = 7'b0001000;
        await_grant(id);
        check_eq("lr_grant", id, 1);
        ack_cycle($urandom);
        bus_en[1] = 1'b0;
        blocked = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs_bus_en) blocked++;
        end
        check_eq("lock_blocks", blocked, 0);
        bus_en[1] = 1'b1;
        op_a[1] = 7'b0001100;
        await_grant(id);
        check_eq("sc_grant", id, 1);
        ack_cycle($urandom);
        bus_en[1] = 1'b0;
        atomic = '0;
        await_grant(id);
        check_eq("after_sc_grant", id, 3);
        ack_cycle($urandom);

        // Lock timeout releases exactly 65 cycles after lock entry
        idle_inputs();
        do_reset();
        bus_en = 4'b0010;
        atomic[1] = 1'b1;
        op_a[1] = 7'b0001000;
        await_grant(id);
        ack_cycle($urandom);
        bus_en = 4'b0001;
        atomic = '0;
        first = -1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (obs_bus_en) begin
                first = i;
                break;
            end
        end
        check_eq("timeout_cycle", first, 65);
        check_eq("timeout_id", obs_id, 0);
        ack_cycle($urandom);

        // Abort keeps port 0's priority
        idle_inputs();
        do_reset();
        bus_en = 4'b0001;
        await_grant(id);
        bus_en = '0;
        cycle();
        cycle();
        check_eq("abort_bus_en", obs_bus_en, 1'b0);
        check_eq("abort_ack", obs_ack, '0);
        bus_en = 4'b0011;
        await_grant(id);
        check_eq("abort_prio", id, 0);
        ack_cycle($urandom);

        // Reset while busy abandons the transaction
        idle_inputs();
        do_reset();
        bus_en = 4'b0010;
        await_grant(id);
        bus_en = 4'b0011;
        rst = 1'b1;
        ack = 1'b1;
        cycle();
        check_eq("rst_busy_ack", obs_ack, '0);
        check_eq("rst_busy_bus_en", obs_bus_en, 1'b0);
        rst = 1'b0;
        ack = 1'b0;
        cycle();
        check_eq("post_rst_bus_en", obs_bus_en, 1'b0);
        await_grant(id);
        check_eq("post_rst_grant", id, 0);
        ack_cycle($urandom);

        // Randomized traffic against the model
        idle_inputs();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!bus_en[p]) begin
                    if ($urandom_range(3) == 0) new_txn(p);
                end else if ($urandom_range(40) == 0) begin
                    bus_en[p] = 1'b0;
                end
            end
            ack     = ($urandom_range(2) == 0);
            rd_data = $urandom;
            rst     = ($urandom_range(299) == 0);
            cycle();
            for (int p = 0; p < N; p++) begin
                if (obs_ack[p]) begin
                    if ($urandom_range(1) == 1) new_txn(p);
                    else bus_en[p] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arbiter_nx1.md
ARBITER_NX1 -- requirements
Module: arbiter_nx1

Interface
REQ-001 SHALL have parameter N_PORTS, default 4: number of requesting buses (2..16).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 64: idle cycles before an LR reservation lock is dropped.
REQ-003 SHALL derive localparam ID_W = max(1, clog2(N_PORTS)).
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
  i_clk  in  1  clock; single clock domain, rising edge
  i_rst  in  1  reset; synchronous, active-high
  i_bus_en  in  N_PORTS  per-port request
  i_wr_en  in  N_PORTS  per-port write (1) / read (0)
  i_wr_data  in  N_PORTS*XLEN  per-port write data, port k at [k*XLEN +: XLEN]
  i_addr  in  N_PORTS*XLEN  per-port address
  i_byte_en  in  N_PORTS*4  per-port byte enables
  i_atomic  in  N_PORTS  per-port atomic flag
  i_operation  in  N_PORTS*7  per-port funct7 (AMO funct5 in [6:2])
  o_ack  out  N_PORTS  per-port completion
  o_rd_data  out  N_PORTS*XLEN  per-port read data
  i_ack  in  1  downstream completion
  i_rd_data  in  XLEN  downstream read data
  o_id  out  ID_W  index of granted port
  o_bus_en, o_wr_en, o_atomic  out  1  downstream request / write / atomic
  o_wr_data, o_addr  out  XLEN  downstream data / address
  o_byte_en  out  4  downstream byte enables
  o_operation  out  7  downstream funct7

Function
REQ-005 SHALL implement states IDLE, BUSY, LOCKED.
REQ-006 IDLE: if any i_bus_en set, SHALL pick winner by round-robin, searching from (last_grant+1) mod N_PORTS upward with wrap, register grant, go to BUSY; else stay IDLE.
REQ-007 Latency: request sampled in IDLE at cycle t SHALL give o_bus_en=1 at t+1.
REQ-008 BUSY: downstream outputs SHALL be a combinational mux of granted port's inputs; o_id = grant.
REQ-009 BUSY with i_ack=1: o_ack[grant]=1 and o_rd_data[grant]=i_rd_data in the same cycle; last_grant<=grant; next state IDLE, or LOCKED per REQ-012.
REQ-010 Non-granted ports SHALL see o_ack=0 and o_rd_data=0 at all times.
REQ-011 BUSY with i_bus_en[grant]=0 and i_ack=0 (abort): SHALL return to IDLE; last_grant unchanged.
REQ-012 Acked transaction with i_atomic=1 and funct5=00010 (LR) SHALL enter LOCKED with owner=grant and timeout counter cleared.
REQ-013 LOCKED: only owner may be granted (to BUSY, next cycle); other requests wait; counter increments each cycle owner is not requesting.
REQ-014 Acked owner transaction that is not LR (SC, AMO, plain) SHALL release the lock (IDLE); a further LR SHALL re-lock and clear the counter.
REQ-015 Counter reaching LOCK_TIMEOUT-1 in LOCKED SHALL release to IDLE next cycle; counter width clog2(LOCK_TIMEOUT)+1, saturating.
REQ-016 No combinational path from i_bus_en to o_bus_en in IDLE/LOCKED; o_bus_en=0 outside BUSY.
REQ-017 N_PORTS=2 with LOCK_TIMEOUT large SHALL behave cycle-compatibly with the existing 2x1 arbiter, except round-robin fairness.

Reset
REQ-018 i_rst=1 at a clock edge SHALL force IDLE, grant=0, last_grant=N_PORTS-1 (port 0 first), lock cleared, counter 0.
REQ-019 During and one cycle after reset all outputs SHALL be 0; a transaction in flight is abandoned with no o_ack.

Structure
REQ-020 XLEN and the LR funct5 encoding SHALL come from defines.vh; no local redefinition.
REQ-021 Round-robin search SHALL be a combinational sub-module rr_picker (inputs request vector, start index; outputs valid, index).
REQ-022 Total RTL SHALL be 120-400 lines; no latches; single always block for state registers.

Verification
REQ-023 Reset, then ports 0..3 all request continuously, downstream acks 1 cycle after each o_bus_en -> grant order 0,1,2,3,0; each o_ack single-cycle.
REQ-024 Port 2 reads 0x100, i_rd_data=0xDEADBEEF with ack -> o_rd_data[2]=0xDEADBEEF, o_ack[2]=1, other o_ack/o_rd_data 0.
REQ-025 Port 1 LR (atomic, funct7=0001000) acked, port 3 requesting -> port 3 blocked; port 1 SC next -> port 1 granted, then port 3.
REQ-026 Port 1 LR acked, then idle 64 cycles with port 0 requesting -> port 0 granted on cycle 65 after lock entry, not earlier.
REQ-027 Port 0 drops i_bus_en in BUSY before ack -> IDLE next cycle, o_bus_en=0, no o_ack, port 0 keeps priority.
REQ-028 i_rst asserted while BUSY -> next cycle all outputs 0, subsequent request from port 0 granted first.
